// File: rtl/prt_tx_drain_pkg.sv
// -----------------------------------------------------------------------------
// prt_pkg
// Shared types and default sizing for the PRT (packet buffer) clients.
// Contents:
//   DATA_WIDTH / NUM_SLOTS / MEM_DEPTH / SLOT_W : default PRT geometry
//   prt_word_t    : one PRT word, complete flag above the data bits
//   prt_slot_t    : slot index
//   drain_state_e : state encoding of the read-side drain FSM
// -----------------------------------------------------------------------------
package prt_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_SLOTS  = 2;
  localparam int MEM_DEPTH  = 2000;
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef struct packed {
    logic                  complete;
    logic [DATA_WIDTH-1:0] data;
  } prt_word_t;

  typedef logic [SLOT_W-1:0] prt_slot_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    READ  = 3'd2,
    FLUSH = 3'd3,
    INVAL = 3'd4
  } drain_state_e;

endpackage

// File: rtl/prt_tx_drain_if.sv
// -----------------------------------------------------------------------------
// prt_tx_drain_if
// Method-style PRT read-side interface (start read / read word / invalidate).
// Every method has an EN_* strobe from the client and a RDY_* from the PRT;
// a method fires on a clock edge where EN is high.
// Modports:
//   master : the drain client (drives EN_* and slot numbers)
//   slave  : the PRT (drives RDY_* and read data)
// read_prt_entry: bit DATA_WIDTH is the complete flag, lower bits are data.
// -----------------------------------------------------------------------------
interface prt_tx_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SLOT_W     = 1
);

  logic                  EN_start_reading_prt_entry;
  logic [SLOT_W-1:0]     start_reading_prt_entry_slot;
  logic                  RDY_start_reading_prt_entry;

  logic                  EN_read_prt_entry;
  logic [DATA_WIDTH:0]   read_prt_entry;
  logic                  RDY_read_prt_entry;

  logic                  EN_invalidate_prt_entry;
  logic [SLOT_W-1:0]     invalidate_prt_entry_slot;
  logic                  RDY_invalidate_prt_entry;

  modport master (
    output EN_start_reading_prt_entry,
    output start_reading_prt_entry_slot,
    input  RDY_start_reading_prt_entry,
    output EN_read_prt_entry,
    input  read_prt_entry,
    input  RDY_read_prt_entry,
    output EN_invalidate_prt_entry,
    output invalidate_prt_entry_slot,
    input  RDY_invalidate_prt_entry
  );

  modport slave (
    input  EN_start_reading_prt_entry,
    input  start_reading_prt_entry_slot,
    output RDY_start_reading_prt_entry,
    input  EN_read_prt_entry,
    output read_prt_entry,
    output RDY_read_prt_entry,
    input  EN_invalidate_prt_entry,
    input  invalidate_prt_entry_slot,
    output RDY_invalidate_prt_entry
  );

endinterface

// File: rtl/prt_tx_drain_skid.sv
// -----------------------------------------------------------------------------
// prt_tx_skid
// One-entry valid/ready holding register.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load        : write load_data into the register (only when can_accept)
//   load_data   : payload to hold
//   out_ready   : downstream accepts the held beat this cycle
//   out_valid   : register holds a beat
//   out_data    : held payload, stable while out_valid && !out_ready
//   can_accept  : register is empty or is being emptied this cycle
// -----------------------------------------------------------------------------
module prt_tx_skid #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_accept
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // A beat leaving in the same cycle frees the slot, so a refill can land
  // on the same edge and the stream runs without bubbles.
  assign can_accept = !valid_q || out_ready;
  assign out_valid  = valid_q;
  assign out_data   = data_q;

  // Load wins over drain: a simultaneous accept + load keeps valid high with
  // the new payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/prt_tx_drain.sv
// -----------------------------------------------------------------------------
// prt_tx_drain
// Read-side client of the PRT packet buffer. Accepts a slot command, starts
// a PRT read, pulls words until the complete flag (or MAX_WORDS), streams
// them on a valid/ready egress port and then invalidates the slot. A drop
// command invalidates the slot without transmitting.
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   cmd_valid/ready     : command handshake, ready only when idle
//   cmd_slot, cmd_drop  : slot to drain, 1 = invalidate only
//   prt                 : PRT method interface (master side)
//   tx_valid/ready      : egress handshake
//   tx_data, tx_last    : egress beat payload, last beat of packet
//   pkt_done            : one-cycle pulse when the invalidate fires
//   err_overrun         : sticky, MAX_WORDS read without a complete flag
// -----------------------------------------------------------------------------
module prt_tx_drain #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_SLOTS  = 2,
  parameter  int MAX_WORDS  = 2000,
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int CNT_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SLOT_W-1:0]     cmd_slot,
  input  logic                  cmd_drop,
  prt_tx_drain_if.master        prt,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_last,
  output logic                  pkt_done,
  output logic                  err_overrun
);

  import prt_pkg::*;

  drain_state_e        state;
  drain_state_e        state_nxt;
  logic [SLOT_W-1:0]   slot_q;
  logic [CNT_W-1:0]    word_cnt;
  logic                armed;
  logic                err_q;

  logic                cmd_fire;
  logic                start_fire;
  logic                rd_fire;
  logic                inv_fire;
  logic                can_accept;
  logic                rd_complete;
  logic                hit_max;
  logic                rd_last;
  logic [DATA_WIDTH:0] skid_out;

  // cmd_ready is held low during reset and for the first edge after it,
  // because "armed" only comes up on the first clock after release.
  assign cmd_ready  = armed && (state == IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;

  // Each EN only follows its RDY inside the owning state, so a low RDY
  // simply parks the FSM with the strobe low.
  assign prt.EN_start_reading_prt_entry   = (state == START) && prt.RDY_start_reading_prt_entry;
  assign prt.start_reading_prt_entry_slot = slot_q;
  assign prt.EN_read_prt_entry            = (state == READ) && prt.RDY_read_prt_entry && can_accept;
  assign prt.EN_invalidate_prt_entry      = (state == INVAL) && prt.RDY_invalidate_prt_entry;
  assign prt.invalidate_prt_entry_slot    = slot_q;

  assign start_fire = prt.EN_start_reading_prt_entry;
  assign rd_fire    = prt.EN_read_prt_entry;
  assign inv_fire   = prt.EN_invalidate_prt_entry;
  assign pkt_done   = inv_fire;

  // The word being read now is the last one either because the PRT says so
  // or because it is word number MAX_WORDS; the counter can never wrap.
  assign rd_complete = prt.read_prt_entry[DATA_WIDTH];
  assign hit_max     = (word_cnt + CNT_W'(1)) == CNT_W'(MAX_WORDS);
  assign rd_last     = rd_complete || hit_max;

  assign tx_last     = skid_out[DATA_WIDTH];
  assign tx_data     = skid_out[DATA_WIDTH-1:0];
  assign err_overrun = err_q;

  // The holding register carries the last flag alongside the data, so a
  // stalled beat keeps both stable.
  prt_tx_skid #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk        (CLK),
    .rst        (RST),
    .load       (rd_fire),
    .load_data  ({rd_last, prt.read_prt_entry[DATA_WIDTH-1:0]}),
    .out_ready  (tx_ready),
    .out_valid  (tx_valid),
    .out_data   (skid_out),
    .can_accept (can_accept)
  );

  // Next-state logic. FLUSH waits for the holding register to drain so the
  // slot is never invalidated while its last beat is still pending.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire)            state_nxt = cmd_drop ? INVAL : START;
      START:   if (start_fire)          state_nxt = READ;
      READ:    if (rd_fire && rd_last)  state_nxt = FLUSH;
      FLUSH:   if (!tx_valid)           state_nxt = INVAL;
      INVAL:   if (inv_fire)            state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // State, latched slot, word counter and sticky overrun flag. Reset drops
  // any packet in flight without invalidating it; upstream re-issues.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      slot_q   <= '0;
      word_cnt <= '0;
      armed    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (cmd_fire) begin
        slot_q <= cmd_slot;
      end
      if (start_fire) begin
        word_cnt <= '0;
      end else if (rd_fire) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (rd_fire && !rd_complete && hit_max) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
